// File: rtl/my_fifo_64_pkg.sv
// Shared widths, the RAM-op encoding and the occupancy helper for the my_fifo_64 controller.
// The optional watermark outputs of the top are enabled with MY_FIFO_64_WATERMARK_EN.
package my_fifo_64_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 64;
  localparam int COUNT_W = 7;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  // Words held overall: RAM-resident words plus the output register.
  function automatic logic [COUNT_W-1:0] occupancy(input logic [COUNT_W-1:0] mem_cnt,
                                                   input logic               out_valid);
    return mem_cnt + {{(COUNT_W-1){1'b0}}, out_valid};
  endfunction

endpackage

// File: rtl/my_fifo_64_arb.sv
// Round-robin arbiter between the push write and the head read-prefetch for the single RAM port.
module my_fifo_64_arb
  import my_fifo_64_pkg::*;
(
  input  logic want_wr,
  input  logic want_rd,
  input  op_t  rr,
  output logic grant_wr,
  output logic grant_rd
);

  // On contention the op that did not win last time takes the port.
  always_comb begin
    if (want_wr && want_rd) begin
      grant_wr = (rr == OP_RD);
      grant_rd = (rr == OP_WR);
    end else begin
      grant_wr = want_wr;
      grant_rd = want_rd;
    end
  end

endmodule

// File: rtl/my_fifo_64_ctrl.sv
// Single-clock FIFO controller owning the one port of an external my_ram_64, with a registered head word.
// Define MY_FIFO_64_WATERMARK_EN to add the AF_LEVEL parameter and the almost_full / hwm outputs.
module my_fifo_64_ctrl #(
  parameter int DATA_W = my_fifo_64_pkg::DATA_W,
  parameter int ADDR_W = my_fifo_64_pkg::ADDR_W
`ifdef MY_FIFO_64_WATERMARK_EN
  ,
  parameter int AF_LEVEL = 60
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic [6:0]        count
`ifdef MY_FIFO_64_WATERMARK_EN
  ,
  output logic              almost_full,
  output logic [6:0]        hwm
`endif
);

  import my_fifo_64_pkg::*;

  localparam logic [COUNT_W-1:0] MEM_FULL = COUNT_W'(2 ** ADDR_W);

  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [COUNT_W-1:0] mem_cnt_r;
  logic [COUNT_W-1:0] mem_cnt_nxt;
  logic               out_valid_r;
  logic               out_valid_nxt;
  logic [DATA_W-1:0]  out_data_r;
  op_t                rr_r;
  logic               want_wr;
  logic               want_rd;
  logic               grant_wr;
  logic               grant_rd;

  // A read-prefetch is only useful when the output register is free or being popped.
  always_comb begin
    want_wr = in_valid && (mem_cnt_r < MEM_FULL);
    want_rd = (mem_cnt_r != {COUNT_W{1'b0}}) && (!out_valid_r || out_ready);
  end

  my_fifo_64_arb u_arb (
    .want_wr  (want_wr),
    .want_rd  (want_rd),
    .rr       (rr_r),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  // RAM port drive; reset forces the write strobe and push handshake low asynchronously.
  always_comb begin
    if (reset) begin
      in_ready = 1'b0;
      ram_load = 1'b0;
      ram_addr = rd_ptr_r;
    end else if (grant_wr) begin
      in_ready = 1'b1;
      ram_load = 1'b1;
      ram_addr = wr_ptr_r;
    end else begin
      in_ready = 1'b0;
      ram_load = 1'b0;
      ram_addr = rd_ptr_r;
    end
  end

  // One RAM op per cycle, so the RAM occupancy moves by at most one.
  always_comb begin
    if (grant_wr) begin
      mem_cnt_nxt = mem_cnt_r + COUNT_W'(1);
    end else if (grant_rd) begin
      mem_cnt_nxt = mem_cnt_r - COUNT_W'(1);
    end else begin
      mem_cnt_nxt = mem_cnt_r;
    end
    if (grant_rd) begin
      out_valid_nxt = 1'b1;
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end else begin
      out_valid_nxt = out_valid_r;
    end
  end

  // Pointers, occupancy, head register and the last-granted op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      mem_cnt_r   <= {COUNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      rr_r        <= OP_WR;
    end else begin
      mem_cnt_r   <= mem_cnt_nxt;
      out_valid_r <= out_valid_nxt;
      if (grant_wr) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (grant_rd) begin
        rd_ptr_r   <= rd_ptr_r + ADDR_W'(1);
        out_data_r <= ram_out;
      end
      if (grant_wr || grant_rd) begin
        rr_r <= grant_wr ? OP_WR : OP_RD;
      end
    end
  end

  assign ram_in    = in_data;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign count     = occupancy(mem_cnt_r, out_valid_r);

`ifdef MY_FIFO_64_WATERMARK_EN
  logic [COUNT_W-1:0] count_nxt;
  logic               almost_full_r;
  logic [COUNT_W-1:0] hwm_r;

  assign count_nxt = occupancy(mem_cnt_nxt, out_valid_nxt);

  // Watermarks track the occupancy that the coming edge establishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full_r <= 1'b0;
      hwm_r         <= {COUNT_W{1'b0}};
    end else begin
      almost_full_r <= (count_nxt >= COUNT_W'(AF_LEVEL));
      if (count_nxt > hwm_r) begin
        hwm_r <= count_nxt;
      end
    end
  end

  assign almost_full = almost_full_r;
  assign hwm         = hwm_r;
`endif

endmodule

// File: tb/tb_my_fifo_64_ctrl.sv
// Self-checking bench for my_fifo_64_ctrl: queue-based reference model, per-cycle compare, directed vectors.
// Build with MY_FIFO_64_WATERMARK_EN defined to also exercise almost_full / hwm with AF_LEVEL = 4.
module tb_my_fifo_64_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;
  logic [6:0]  count;
`ifdef MY_FIFO_64_WATERMARK_EN
  logic        almost_full;
  logic [6:0]  hwm;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef MY_FIFO_64_WATERMARK_EN
  my_fifo_64_ctrl #(.AF_LEVEL(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ram_addr    (ram_addr),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .count       (count),
    .almost_full (almost_full),
    .hwm         (hwm)
  );
`else
  my_fifo_64_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ram_addr  (ram_addr),
    .ram_in    (ram_in),
    .ram_load  (ram_load),
    .ram_out   (ram_out),
    .count     (count)
  );
`endif

  // Stand-in for my_ram_64: combinational read, synchronous write.
  logic [15:0] ram [64];
  assign ram_out = ram[ram_addr];
  always @(posedge clk) begin
    if (ram_load) ram[ram_addr] <= ram_in;
  end

  // Reference model: words in the RAM as an ordered queue, plus the head register.
  logic [15:0] m_q[$];
  logic        m_ov;
  logic [15:0] m_od;
  logic        m_last_rd;
  int unsigned m_wr_n;
  int unsigned m_rd_n;
  int          m_hwm;
  logic        m_af;
  logic        check_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  function automatic logic m_wants_rd(input logic ordy);
    return (m_q.size() > 0) && (!m_ov || ordy);
  endfunction

  function automatic logic m_wants_wr(input logic iv);
    return iv && (m_q.size() < 64);
  endfunction

  function automatic logic m_gw(input logic iv, input logic ordy);
    return m_wants_wr(iv) && (!m_wants_rd(ordy) || m_last_rd);
  endfunction

  function automatic logic m_gr(input logic iv, input logic ordy);
    return m_wants_rd(ordy) && (!m_wants_wr(iv) || !m_last_rd);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ov      = 1'b0;
    m_od      = 16'h0000;
    m_last_rd = 1'b0;
    m_wr_n    = 0;
    m_rd_n    = 0;
    m_hwm     = 0;
    m_af      = 1'b0;
  endtask

  // Per-cycle compare, half a period away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      if (reset) begin
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ram_load", 32'(ram_load), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("in_ready", 32'(in_ready), 32'(m_gw(in_valid, out_ready)));
        check("ram_load", 32'(ram_load), 32'(m_gw(in_valid, out_ready)));
        check("ram_addr", 32'(ram_addr),
              m_gw(in_valid, out_ready) ? 32'(m_wr_n % 64) : 32'(m_rd_n % 64));
        check("ram_in", 32'(ram_in), 32'(in_data));
        check("count", 32'(count), 32'(m_q.size()) + 32'(m_ov));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_od));
`ifdef MY_FIFO_64_WATERMARK_EN
        check("almost_full", 32'(almost_full), 32'(m_af));
        check("hwm", 32'(hwm), 32'(m_hwm));
`endif
      end
    end
  end

  task automatic drive(input logic iv, input logic [15:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Advance one edge and apply the same edge to the model.
  task automatic edge_();
    logic gw;
    logic gr;
    int   nc;
    @(posedge clk);
    if (!reset) begin
      gw = m_gw(in_valid, out_ready);
      gr = m_gr(in_valid, out_ready);
      if (gw) begin
        m_q.push_back(in_data);
        m_wr_n++;
        m_last_rd = 1'b0;
      end
      if (gr) begin
        m_od = m_q.pop_front();
        m_ov = 1'b1;
        m_rd_n++;
        m_last_rd = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      nc   = m_q.size() + int'(m_ov);
      m_af = (nc >= 4);
      if (nc > m_hwm) m_hwm = nc;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] v, input logic ordy);
    bit done = 1'b0;
    drive(1'b1, v, ordy);
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (in_ready) done = 1'b1;
      edge_();
    end
    drive(1'b0, 16'h0000, ordy);
    if (!done) fail_now("push_timeout");
  endtask

  task automatic pop_word(input logic [15:0] exp);
    bit got = 1'b0;
    drive(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        check("pop_data", 32'(out_data), 32'(exp));
      end
      edge_();
    end
    drive(1'b0, 16'h0000, 1'b0);
    if (!got) fail_now("pop_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        prev_load;
    logic [15:0] next_data;
    int          start_cnt;

    reset    = 1'b0;
    check_en = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    model_reset();
    #1;
    reset    = 1'b1;
    check_en = 1'b1;

    // Reset then idle
    drive(1'b1, 16'h5555, 1'b1);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_ram_load", 32'(ram_load), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_ram_load", 32'(ram_load), 32'd0);

    // Single push of 0xBEEF: write edge, then read edge, no bypass
    drive(1'b1, 16'hBEEF, 1'b0);
    #1;
    check("beef_ram_load", 32'(ram_load), 32'd1);
    check("beef_ram_addr", 32'(ram_addr), 32'd0);
    check("beef_in_ready", 32'(in_ready), 32'd1);
    edge_();
    drive(1'b0, 16'h0000, 1'b0);
    #1;
    check("beef_no_bypass", 32'(out_valid), 32'd0);
    check("beef_count1", 32'(count), 32'd1);
    edge_();
    check("beef_out_valid", 32'(out_valid), 32'd1);
    check("beef_out_data", 32'(out_data), 32'hBEEF);
    check("beef_count2", 32'(count), 32'd1);
    drive(1'b0, 16'h0000, 1'b1);
    edge_();
    check("beef_popped", 32'(count), 32'd0);
    drive(1'b0, 16'h0000, 1'b0);

    // Fill to 65 words, stall the 66th, drain in order
    do_reset();
    for (int k = 0; k < 65; k++) push_word(16'(k), 1'b0);
    check("full_count", 32'(count), 32'd65);
    drive(1'b1, 16'hDEAD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_in_ready", 32'(in_ready), 32'd0);
      edge_();
    end
    check("full_count_held", 32'(count), 32'd65);
    for (int k = 0; k < 65; k++) pop_word(16'(k));
    check("drained_count", 32'(count), 32'd0);
    drive(1'b1, 16'h1234, 1'b0);
    #1;
    check("wrap_wr_addr", 32'(ram_addr), 32'd1);
    check("wrap_wr_load", 32'(ram_load), 32'd1);
    edge_();
    drive(1'b0, 16'h0000, 1'b0);
    #1;
    check("wrap_rd_addr", 32'(ram_addr), 32'd1);
    check("wrap_rd_load", 32'(ram_load), 32'd0);
    edge_();

    // Steady push+pop stream: ops alternate and occupancy stays bounded
    push_word(16'h2000, 1'b0);
    start_cnt = m_q.size() + int'(m_ov);
    check("stream_start", 32'(count), 32'd2);
    next_data = 16'h3000;
    prev_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, next_data, 1'b1);
      #1;
      if (i > 0) check("stream_alternate", 32'(ram_load), 32'(!prev_load));
      prev_load = ram_load;
      if (in_ready) next_data = next_data + 16'd1;
      check("stream_cnt_bound", 32'(int'(count) <= start_cnt + 1), 32'd1);
      edge_();
    end
    drive(1'b0, 16'h0000, 1'b1);
    repeat (6) edge_();
    check("stream_drained", 32'(count), 32'd0);
    drive(1'b0, 16'h0000, 1'b0);

    // Asynchronous reset with 10 words held
    do_reset();
    for (int k = 0; k < 10; k++) push_word(16'h0100 + 16'(k), 1'b0);
    check("ten_count", 32'(count), 32'd10);
    drive(1'b1, 16'h7777, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    check("async_ram_load", 32'(ram_load), 32'd0);
    drive(1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_word(16'h00AA, 1'b0);
    push_word(16'h00BB, 1'b0);
    pop_word(16'h00AA);
    pop_word(16'h00BB);

`ifdef MY_FIFO_64_WATERMARK_EN
    // Watermarks with AF_LEVEL = 4
    do_reset();
    for (int k = 0; k < 3; k++) push_word(16'h0A00 + 16'(k), 1'b0);
    check("wm_count3", 32'(count), 32'd3);
    check("wm_af_low", 32'(almost_full), 32'd0);
    push_word(16'h0A03, 1'b0);
    check("wm_count4", 32'(count), 32'd4);
    check("wm_af_high", 32'(almost_full), 32'd1);
    pop_word(16'h0A00);
    pop_word(16'h0A01);
    check("wm_count2", 32'(count), 32'd2);
    check("wm_hwm", 32'(hwm), 32'd4);
    check("wm_af_clear", 32'(almost_full), 32'd0);
`endif

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
